// File: rtl/post_adder_carryout_if.sv
// Operand, enable and result bundle for the DSP48A1 post-adder / carry-out stage.
// The master side drives operands and enables; the slave side returns P, carry-out and valid.
interface post_adder_carryout_if;
    logic        CEP;
    logic        CECARRYIN;
    logic [7:0]  OPMODE;
    logic [47:0] X;
    logic [47:0] C;
    logic [47:0] PCIN;
    logic        CARRYIN_mux;
    logic        VALID_IN;
    logic [47:0] P;
    logic [47:0] PCOUT;
    logic        CARRYOUT;
    logic        CARRYOUTF;
    logic        VALID_OUT;

    modport master (
        output CEP, CECARRYIN, OPMODE, X, C, PCIN, CARRYIN_mux, VALID_IN,
        input  P, PCOUT, CARRYOUT, CARRYOUTF, VALID_OUT
    );

    modport slave (
        input  CEP, CECARRYIN, OPMODE, X, C, PCIN, CARRYIN_mux, VALID_IN,
        output P, PCOUT, CARRYOUT, CARRYOUTF, VALID_OUT
    );
endinterface

// File: rtl/post_adder_carryout.sv
// DSP48A1 post-adder/subtracter: Z-mux, 49-bit add/sub, optional P and carry-out registers.
// All registers share the asynchronous, active-high RSTCARRYIN domain.
module post_adder_carryout #(
    parameter bit PREG        = 1'b1,
    parameter bit CARRYOUTREG = 1'b1
) (
    input logic                   CLK,
    input logic                   RSTCARRYIN,
    post_adder_carryout_if.slave  bus
);

    logic [47:0] p_reg;
    logic        co_reg;
    logic        valid_reg;
    logic [47:0] z;
    logic [48:0] addend;
    logic [48:0] sum;
    logic        unused_opmode;

    assign unused_opmode = ^{bus.OPMODE[6:4], bus.OPMODE[1:0]};

    always_comb begin
        z = '0;
        case (bus.OPMODE[3:2])
            2'b00: z = '0;
            2'b01: z = bus.PCIN;
            // Feedback only exists when P is registered, so no combinational loop can form.
            2'b10: z = PREG ? p_reg : '0;
            2'b11: z = bus.C;
            default: z = '0;
        endcase
    end

    always_comb begin
        addend = {1'b0, bus.X} + {48'b0, bus.CARRYIN_mux};
        if (bus.OPMODE[7])
            sum = {1'b0, z} - addend;
        else
            sum = {1'b0, z} + addend;
    end

    always_ff @(posedge CLK or posedge RSTCARRYIN) begin
        if (RSTCARRYIN) begin
            p_reg     <= '0;
            co_reg    <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            if (bus.CEP) begin
                p_reg     <= sum[47:0];
                valid_reg <= bus.VALID_IN;
            end
            if (bus.CECARRYIN)
                co_reg <= sum[48];
        end
    end

    assign bus.P         = PREG ? p_reg : sum[47:0];
    assign bus.PCOUT     = bus.P;
    assign bus.CARRYOUT  = CARRYOUTREG ? co_reg : sum[48];
    assign bus.CARRYOUTF = bus.CARRYOUT;
    assign bus.VALID_OUT = PREG ? valid_reg : bus.VALID_IN;

endmodule

// File: tb/tb_post_adder_carryout.sv
// Self-checking bench: a registered instance and a combinational instance share one stimulus
// stream and are compared every step against a plain-arithmetic model of the post-adder.
module tb_post_adder_carryout;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  opmode;
    logic [47:0] x, c, pcin;
    logic        cin, vin, cep, ceci;

    int tests = 0;
    int fails = 0;

    // Model state: contents of the P, carry-out and valid registers.
    logic [47:0] m_p;
    logic        m_co;
    logic        m_v;

    post_adder_carryout_if ifr ();
    post_adder_carryout_if ifc ();

    assign ifr.CEP = cep;          assign ifc.CEP = cep;
    assign ifr.CECARRYIN = ceci;   assign ifc.CECARRYIN = ceci;
    assign ifr.OPMODE = opmode;    assign ifc.OPMODE = opmode;
    assign ifr.X = x;              assign ifc.X = x;
    assign ifr.C = c;              assign ifc.C = c;
    assign ifr.PCIN = pcin;        assign ifc.PCIN = pcin;
    assign ifr.CARRYIN_mux = cin;  assign ifc.CARRYIN_mux = cin;
    assign ifr.VALID_IN = vin;     assign ifc.VALID_IN = vin;

    post_adder_carryout #(.PREG(1'b1), .CARRYOUTREG(1'b1)) dut_r (
        .CLK(clk), .RSTCARRYIN(rst), .bus(ifr)
    );

    post_adder_carryout #(.PREG(1'b0), .CARRYOUTREG(1'b0)) dut_c (
        .CLK(clk), .RSTCARRYIN(rst), .bus(ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [48:0] post_add(input logic [7:0] op, input logic [47:0] zv,
                                             input logic [47:0] xv, input logic ci);
        logic [48:0] rhs;
        rhs = 49'(xv) + 49'(ci);
        return op[7] ? (49'(zv) - rhs) : (49'(zv) + rhs);
    endfunction

    function automatic logic [47:0] z_of(input logic [7:0] op, input logic has_preg);
        case (op[3:2])
            2'b01:   return pcin;
            2'b10:   return has_preg ? m_p : 48'd0;
            2'b11:   return c;
            default: return 48'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [48:0] act, input logic [48:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [48:0] s_c;
        s_c = post_add(opmode, z_of(opmode, 1'b0), x, cin);
        chk("r_P",         49'(ifr.P),         49'(m_p));
        chk("r_PCOUT",     49'(ifr.PCOUT),     49'(m_p));
        chk("r_CARRYOUT",  49'(ifr.CARRYOUT),  49'(m_co));
        chk("r_CARRYOUTF", 49'(ifr.CARRYOUTF), 49'(m_co));
        chk("r_VALID_OUT", 49'(ifr.VALID_OUT), 49'(m_v));
        chk("c_P",         49'(ifc.P),         49'(s_c[47:0]));
        chk("c_PCOUT",     49'(ifc.PCOUT),     49'(s_c[47:0]));
        chk("c_CARRYOUT",  49'(ifc.CARRYOUT),  49'(s_c[48]));
        chk("c_CARRYOUTF", 49'(ifc.CARRYOUTF), 49'(s_c[48]));
        chk("c_VALID_OUT", 49'(ifc.VALID_OUT), 49'(vin));
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (v) begin
            m_p  = '0;
            m_co = 1'b0;
            m_v  = 1'b0;
        end
        #1;
        compare_all();
    endtask

    // One rising edge: advance the model with pre-edge values, then check just after the edge.
    task automatic tick();
        logic [48:0] s;
        @(posedge clk);
        s = post_add(opmode, z_of(opmode, 1'b1), x, cin);
        if (!rst) begin
            if (cep) begin
                m_p = s[47:0];
                m_v = vin;
            end
            if (ceci)
                m_co = s[48];
        end
        #1;
        compare_all();
    endtask

    initial begin
        logic [47:0] acc_exp [4];
        acc_exp = '{48'd4, 48'd8, 48'd12, 48'd16};

        opmode = '0; x = '0; c = '0; pcin = '0;
        cin = 1'b0; vin = 1'b0; cep = 1'b0; ceci = 1'b0;
        rst = 1'b1; m_p = '0; m_co = 1'b0; m_v = 1'b0;
        #2;
        compare_all();
        chk("reset_P",     49'(ifr.P),         49'd0);
        chk("reset_CO",    49'(ifr.CARRYOUT),  49'd0);
        chk("reset_VALID", 49'(ifr.VALID_OUT), 49'd0);
        set_rst(1'b0);

        // Add with carry out of bit 47
        opmode = 8'h0C; c = 48'hFFFF_FFFF_FFFF; x = '0; cin = 1'b1;
        vin = 1'b1; cep = 1'b1; ceci = 1'b1;
        tick();
        chk("addc_P",     49'(ifr.P),         49'd0);
        chk("addc_CO",    49'(ifr.CARRYOUT),  49'd1);
        chk("addc_COF",   49'(ifr.CARRYOUTF), 49'd1);
        chk("addc_VALID", 49'(ifr.VALID_OUT), 49'd1);

        // Subtract with and without borrow
        opmode = 8'h8C; c = 48'd5; x = 48'd7; cin = 1'b0;
        tick();
        chk("subb_P",  49'(ifr.P),        49'h0_FFFF_FFFF_FFFE);
        chk("subb_CO", 49'(ifr.CARRYOUT), 49'd1);
        c = 48'd10;
        tick();
        chk("sub_P",  49'(ifr.P),        49'd3);
        chk("sub_CO", 49'(ifr.CARRYOUT), 49'd0);

        // Accumulate from reset, then stall
        set_rst(1'b1);
        set_rst(1'b0);
        opmode = 8'h08; x = 48'd3; cin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("acc_P", 49'(ifr.P), 49'(acc_exp[i]));
        end
        chk("acc_comb_zero_P", 49'(ifc.P), 49'd4);
        cep = 1'b0; ceci = 1'b0; vin = 1'b0;
        tick();
        tick();
        chk("stall_P",     49'(ifr.P),         49'd16);
        chk("stall_VALID", 49'(ifr.VALID_OUT), 49'd1);

        // Reset between edges mid-accumulation, then an enabled edge under reset
        cep = 1'b1; ceci = 1'b1; vin = 1'b1;
        opmode = 8'h0C; c = 48'h120; x = 48'd2; cin = 1'b1;
        tick();
        chk("pre_rst_P", 49'(ifr.P), 49'h123);
        opmode = 8'h08; x = 48'd1; cin = 1'b0;
        set_rst(1'b1);
        chk("async_rst_P",  49'(ifr.P),        49'd0);
        chk("async_rst_CO", 49'(ifr.CARRYOUT), 49'd0);
        tick();
        chk("held_rst_P", 49'(ifr.P), 49'd0);
        set_rst(1'b0);

        // Combinational instance
        cep = 1'b0; ceci = 1'b0;
        tick();
        opmode = 8'h04; pcin = 48'd100; x = 48'd20; cin = 1'b1;
        #1;
        compare_all();
        chk("comb_P",  49'(ifc.P),        49'd121);
        chk("comb_CO", 49'(ifc.CARRYOUT), 49'd0);
        opmode = 8'h08;
        #1;
        compare_all();
        chk("comb_nofb_P", 49'(ifc.P), 49'd21);

        // Split enables: P loads, carry-out register keeps 0
        tick();
        set_rst(1'b1);
        set_rst(1'b0);
        opmode = 8'h0C; c = 48'hFFFF_FFFF_FFFF; x = 48'd2; cin = 1'b0;
        cep = 1'b1; ceci = 1'b0;
        tick();
        chk("split_P",    49'(ifr.P),        49'd1);
        chk("split_CO",   49'(ifr.CARRYOUT), 49'd0);
        chk("split_c_CO", 49'(ifc.CARRYOUT), 49'd1);

        // Randomised phase
        for (int n = 0; n < 400; n++) begin
            opmode = 8'($urandom);
            x      = {16'($urandom), $urandom};
            c      = {16'($urandom), $urandom};
            pcin   = {16'($urandom), $urandom};
            if ($urandom_range(0, 7) == 0) x = '1;
            if ($urandom_range(0, 7) == 0) c = '1;
            if ($urandom_range(0, 7) == 0) x = 48'(n);
            cin  = 1'($urandom);
            vin  = 1'($urandom);
            cep  = ($urandom_range(0, 3) != 0);
            ceci = ($urandom_range(0, 3) != 0);
            #1;
            compare_all();
            if ($urandom_range(0, 31) == 0)
                set_rst(1'b1);
            else if (rst)
                set_rst(1'b0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/post_adder_carryout.md
# post_adder_carryout

Post-adder/subtracter stage of the DSP48A1 slice, directly downstream of the carry-in register. It consumes the selected carry-in (CARRYIN_mux) and the X-mux result, forms the Z operand internally, computes the 48-bit sum or difference, and holds the result (P) and carry-out (CARRYOUT/CARRYOUTF). Its registers accumulate when Z selects P. All of its registers share the carry reset domain.

## Interface
- PREG, 1: 1 = P output registered; 0 = combinational.
- CARRYOUTREG, 1: 1 = carry-out registered; 0 = combinational.
- CLK  in  1  clock; all registers update on the rising edge.
- RSTCARRYIN  in  1  reset, asynchronous, active-high; clears the P, CARRYOUT and valid registers.
- CEP  in  1  clock enable for the P register.
- CECARRYIN  in  1  clock enable for the carry-out register.
- OPMODE  in  8  only [7] and [3:2] are used. [7]: 1 = subtract. [3:2]: Z select.
- X  in  48  X-mux result from upstream.
- C  in  48  C operand, already registered upstream.
- PCIN  in  48  cascade input from the neighbouring slice.
- CARRYIN_mux  in  1  carry-in from the carry-in register stage.
- VALID_IN  in  1  operand-valid tag.
- P  out  48  post-adder result.
- PCOUT  out  48  always equal to P.
- CARRYOUT  out  1  carry/borrow out of bit 47.
- CARRYOUTF  out  1  always equal to CARRYOUT (fabric copy).
- VALID_OUT  out  1  VALID_IN delayed to match the P latency.

## Operation
- Z mux, selected by OPMODE[3:2]:
  - 00: zero.
  - 01: PCIN.
  - 10: current P register value when PREG=1; zero when PREG=0, so no combinational loop can form.
  - 11: C.
- Arithmetic is done at 49 bits, with operands zero-extended:
  - Add (OPMODE[7]=0): S = Z + X + CARRYIN_mux.
  - Subtract (OPMODE[7]=1): S = Z − (X + CARRYIN_mux).
- P_next = S[47:0], modulo 2^48, so it wraps with no saturation.
- CO_next = S[48]. On add this is the carry. On subtract it is the borrow: 1 when Z < X + CARRYIN_mux.
- Registers:
  - P register: loads P_next when CEP=1, otherwise holds.
  - Carry-out register: loads CO_next when CECARRYIN=1, otherwise holds.
  - Valid register: loads VALID_IN when CEP=1.
- Output muxes:
  - P = PREG ? P register : P_next.
  - CARRYOUT = CARRYOUTREG ? carry-out register : CO_next.
  - VALID_OUT = PREG ? valid register : VALID_IN.
- Accumulate mode (OPMODE[3:2]=10, PREG=1): the register adds X+CIN, or subtracts it, every enabled cycle, forming a running sum.
- Reset:
  - Asserting RSTCARRYIN clears the P register, carry-out register and valid register to 0 immediately, independent of CLK.
  - Reset overrides CEP and CECARRYIN.
  - After reset, an accumulation restarts from 0.
- The P and carry-out enables are independent, so a CEP/CECARRYIN mismatch can leave P and CARRYOUT from different operations. This is legal and is not corrected.

## Timing
- Reset values: P=0, PCOUT=0, CARRYOUT=0, CARRYOUTF=0, VALID_OUT=0 when the corresponding register is enabled by parameter.
  - Outputs with PREG=0 or CARRYOUTREG=0 follow their inputs combinationally during reset.
- Latency:
  - PREG=1 / CARRYOUTREG=1: result visible one CLK edge after the operands are sampled.
  - PREG=0 / CARRYOUTREG=0: zero cycles, combinational.
- Simultaneous events:
  - Reset deasserted on the same edge as CEP=1: that edge loads P_next.
  - Deassertion is asynchronous; the integrator synchronises it.
- Accumulate feedback uses the pre-edge P value, giving one addition per enabled edge.
- Stall: with CEP=0, P and VALID_OUT hold for any number of cycles, and operand changes have no effect.
- OPMODE changes take effect on the next enabled edge. There is no pipeline of OPMODE inside this block.

## Test plan
- Reset: assert RSTCARRYIN mid-accumulation (P=0x123) between clock edges -> P=0 and CARRYOUT=0 immediately; with CEP=1 held and reset still high, the next edge keeps P=0.
- Add with carry (PREG=1, CARRYOUTREG=1): OPMODE=0x0C (Z=C), C=0xFFFF_FFFF_FFFF, X=0, CARRYIN_mux=1 -> after 1 edge P=0, CARRYOUT=1, CARRYOUTF=1.
- Subtract with borrow: OPMODE=0x8C, C=5, X=7, CIN=0 -> P=0xFFFF_FFFF_FFFE, CARRYOUT=1. Repeat with C=10 -> P=3, CARRYOUT=0.
- Accumulate: OPMODE=0x08, X=3, CIN=1, CEP=1 for 4 edges from reset -> P=4, 8, 12, 16. Drop CEP for 2 edges -> P holds at 16 and VALID_OUT holds.
- Combinational mode (PREG=0, CARRYOUTREG=0): OPMODE=0x04, PCIN=100, X=20, CIN=1 -> P=121 and CARRYOUT=0 in the same cycle. OPMODE=0x08 -> Z=0, so P=21.
- Split enables: CEP=1, CECARRYIN=0 on a carry-producing add -> P updates while CARRYOUT keeps its prior value 0.
